// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared types and constants for mux4_rr_arbiter
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  // Pointer value after reset; requester 0 is searched first.
  localparam logic [IDX_W-1:0] RST_LAST = 2'd3;

endpackage

// File: rtl/mux4to1.sv
// rtl/mux4to1.sv - combinational 4:1 word mux, every select value decoded
module mux4to1 #(
  parameter int dwidth = 2
) (
  input  logic [1:0]        sel,
  input  logic [dwidth-1:0] d0,
  input  logic [dwidth-1:0] d1,
  input  logic [dwidth-1:0] d2,
  input  logic [dwidth-1:0] d3,
  output logic [dwidth-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - 4-requester round-robin arbiter with registered output beat
// Optional lock/regrant behaviour: MUX4_RR_ARBITER_LOCK_EN
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DWIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DWIDTH-1:0] data0,
  input  logic [DWIDTH-1:0] data1,
  input  logic [DWIDTH-1:0] data2,
  input  logic [DWIDTH-1:0] data3,
  output logic [3:0]        ack,
  output logic [DWIDTH-1:0] dout,
  output logic [1:0]        dout_src,
  output logic              dout_vld,
  input  logic              dout_rdy,
  input  logic [3:0]        lock
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [DWIDTH-1:0]  dout_q, dout_d;
  logic [IDX_W-1:0]   grant;
  logic [DWIDTH-1:0]  mux_y;
  logic               locked;
  logic               capture_en;

  // Scan from last+4 down to last+1 so the nearest set request after last wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

`ifdef MUX4_RR_ARBITER_LOCK_EN
  assign locked = lock[last_q] & req[last_q];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign locked      = 1'b0;
`endif

  assign grant = locked ? last_q : rr_pick(req, last_q);

  mux4to1 #(.dwidth(DWIDTH)) u_mux (
    .sel (grant),
    .d0  (data0),
    .d1  (data1),
    .d2  (data2),
    .d3  (data3),
    .y   (mux_y)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    src_d      = src_q;
    dout_d     = dout_q;
    ack        = '0;
    capture_en = (state_q == ST_EMPTY) || dout_rdy;
    if (capture_en) begin
      if (|req) begin
        state_d = ST_FULL;
        dout_d  = mux_y;
        src_d   = grant;
        if (!locked) last_d = grant;
        // No handshake while reset discards the capture, so the requester keeps its word.
        if (!reset) ack = NUM_REQ'(1) << grant;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      last_q  <= RST_LAST;
      src_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      dout_q  <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign dout_src = src_q;
  assign dout_vld = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed and randomized checks of mux4_rr_arbiter against a reference model
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [1:0] data0, data1, data2, data3;
  logic [3:0] ack;
  logic [1:0] dout;
  logic [1:0] dout_src;
  logic       dout_vld;
  logic       dout_rdy;
  logic [3:0] lock;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DWIDTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .ack      (ack),
    .dout     (dout),
    .dout_src (dout_src),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .lock     (lock)
  );

`ifdef MUX4_RR_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the held beat and the round-robin pointer.
  bit   m_init = 0;
  bit   m_vld  = 0;
  int   m_dout = 0;
  int   m_src  = 0;
  int   m_last = 3;

  logic [1:0] wd [4];
  logic [3:0] obs_ack;
  logic       obs_vld;
  logic [1:0] obs_dout, obs_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int model_pick(input logic [3:0] r, input logic [3:0] lk);
    if (LOCK_EN && lk[m_last] && r[m_last]) return m_last;
    for (int k = 1; k <= 4; k++) begin
      int i = (m_last + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] lk,
                      input logic rdy, output int g);
    bit         hit;
    logic [3:0] exp_ack;
    reset = rst; req = r; lock = lk; dout_rdy = rdy;
    data0 = wd[0]; data1 = wd[1]; data2 = wd[2]; data3 = wd[3];
    g   = -1;
    hit = LOCK_EN && lk[m_last] && r[m_last];
    if (!rst && (!m_vld || rdy) && r != 4'b0) g = model_pick(r, lk);
    exp_ack = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    @(negedge clk);
    obs_ack = ack; obs_vld = dout_vld; obs_dout = dout; obs_src = dout_src;
    if (m_init) begin
      check("ack", 32'(ack), 32'(exp_ack));
      check("dout_vld", 32'(dout_vld), 32'(m_vld));
      if (m_vld) begin
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_src", 32'(dout_src), 32'(m_src));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_dout = 0; m_src = 0; m_last = 3; m_init = 1;
    end else if (!m_vld || rdy) begin
      if (g >= 0) begin
        m_vld = 1; m_dout = int'(wd[g]); m_src = g;
        if (!hit) m_last = g;
      end else begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  initial begin
    int         g;
    logic [3:0] pend;
    logic [3:0] rr_tbl [5];
    rr_tbl[0] = 4'b0001; rr_tbl[1] = 4'b0010; rr_tbl[2] = 4'b0100;
    rr_tbl[3] = 4'b1000; rr_tbl[4] = 4'b0001;
    for (int n = 0; n < 4; n++) wd[n] = 2'(n);
    reset = 1'b1; req = '0; lock = '0; dout_rdy = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    @(posedge clk); #1;

    step(1'b1, 4'b0, 4'b0, 1'b0, g);
    step(1'b0, 4'b0, 4'b0, 1'b0, g);
    check("reset_vld", 32'(obs_vld), 32'd0);
    check("reset_dout", 32'(obs_dout), 32'd0);
    check("reset_src", 32'(obs_src), 32'd0);

    // Full request vector rotates through all requesters.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 4'b0, 1'b1, g);
      check("rr_seq_ack", 32'(obs_ack), 32'(rr_tbl[i]));
    end

    // Single requester latency.
    step(1'b1, 4'b0, 4'b0, 1'b0, g);
    wd[2] = 2'b10;
    step(1'b0, 4'b0100, 4'b0, 1'b1, g);
    check("lat_ack", 32'(obs_ack), 32'b0100);
    step(1'b0, 4'b0, 4'b0, 1'b0, g);
    check("lat_vld", 32'(obs_vld), 32'd1);
    check("lat_dout", 32'(obs_dout), 32'b10);
    check("lat_src", 32'(obs_src), 32'd2);

    // Backpressure holds the beat, then the next requester after 2 is captured.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 4'b0, 1'b0, g);
      check("stall_ack", 32'(obs_ack), 32'd0);
      check("stall_dout", 32'(obs_dout), 32'b10);
    end
    step(1'b0, 4'b1111, 4'b0, 1'b1, g);
    check("stall_release_ack", 32'(obs_ack), 32'b1000);

    // Drain to empty, then a lone request from requester 1.
    step(1'b0, 4'b0, 4'b0, 1'b1, g);
    check("drain_ack", 32'(obs_ack), 32'd0);
    step(1'b0, 4'b0010, 4'b0, 1'b1, g);
    check("drain_vld", 32'(obs_vld), 32'd0);
    check("drain_req1_ack", 32'(obs_ack), 32'b0010);
    step(1'b0, 4'b0, 4'b0, 1'b0, g);
    check("drain_req1_src", 32'(obs_src), 32'd1);

    // Reset while a stalled beat is held.
    step(1'b1, 4'b1111, 4'b0, 1'b0, g);
    check("rst_full_ack", 32'(obs_ack), 32'd0);
    step(1'b0, 4'b1111, 4'b0, 1'b0, g);
    check("rst_full_vld", 32'(obs_vld), 32'd0);
    check("rst_full_first", 32'(obs_ack), 32'b0001);

    // Randomized traffic: requesters hold their word until acknowledged.
    pend = 4'b0001;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (!pend[n] && ($urandom_range(1, 0) == 1)) begin
          pend[n] = 1'b1;
          wd[n]   = 2'($urandom);
        end
      end
      step(($urandom_range(63, 0) == 0), pend, 4'($urandom),
           ($urandom_range(3, 0) != 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
